control_sequencer: RTL and testbench

Instruction sequencer for the 16-bit ALU/register/memory datapath: the block on the other end of the datapath's control-word interface. It drives every select, function, enable and memory strobe the datapath consumes, and reads back only the instruction register contents and the ALU flags. It implements a fixed 3-cycle fetch/fetch/execute machine over a small instruction set, with a halt state.

---
 rtl/control_pkg.sv | 112 +++++++++++
 rtl/instr_decoder.sv | 99 +++++++++
 rtl/control_sequencer.sv | 113 +++++++++++
 tb/tb_control_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg
//   Shared encodings for the control sequencer: state codes, opcodes,
//   register-file / address-register-file function codes, ALU operation
//   codes, address-register read selects and the packed control word that
//   the sequencer presents to the datapath (with its idle value).
package control_pkg;

    // Sequencer states; the encoding doubles as the debug T output.
    typedef enum logic [1:0] {
        ST_T0   = 2'b00,  // fetch low byte
        ST_T1   = 2'b01,  // fetch high byte
        ST_T2   = 2'b10,  // execute
        ST_HALT = 2'b11
    } state_t;

    // Opcodes (IR[15:10])
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_INC  = 6'h01;
    localparam logic [5:0] OP_DEC  = 6'h02;
    localparam logic [5:0] OP_ADD  = 6'h03;
    localparam logic [5:0] OP_SUB  = 6'h04;
    localparam logic [5:0] OP_AND  = 6'h05;
    localparam logic [5:0] OP_ORR  = 6'h06;
    localparam logic [5:0] OP_MOVL = 6'h07;
    localparam logic [5:0] OP_LD   = 6'h08;
    localparam logic [5:0] OP_ST   = 6'h09;
    localparam logic [5:0] OP_BRA  = 6'h0A;
    localparam logic [5:0] OP_BEQ  = 6'h0B;
    localparam logic [5:0] OP_HLT  = 6'h3F;

    // RF / ARF function codes (shared encoding)
    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    // ALU operation codes
    localparam logic [4:0] ALU_PASS_A = 5'h10;
    localparam logic [4:0] ALU_ADD    = 5'h14;
    localparam logic [4:0] ALU_SUB    = 5'h16;
    localparam logic [4:0] ALU_AND    = 5'h17;
    localparam logic [4:0] ALU_ORR    = 5'h18;

    // Address register file read selects
    localparam logic [1:0] ARF_SEL_PC = 2'b00;
    localparam logic [1:0] ARF_SEL_SP = 2'b01;
    localparam logic [1:0] ARF_SEL_AR = 2'b10;

    // Datapath mux selects used by the decoder
    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_MEM = 2'b10;
    localparam logic [1:0] MUXA_IMM = 2'b11;
    localparam logic [1:0] MUXB_ARF = 2'b01;

    // ARF write enables {PC,AR,SP}, active-low: PC only
    localparam logic [2:0] ARF_WR_PC   = 3'b011;
    localparam logic [2:0] ARF_WR_NONE = 3'b111;

    typedef struct packed {
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_outc_sel;
        logic [1:0] arf_outd_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxa_sel;
        logic [1:0] muxb_sel;
        logic       muxc_sel;
    } ctrl_word_t;

    // Nothing written, memory deselected, all selects zero.
    localparam ctrl_word_t IDLE_WORD = '{
        rf_outa_sel:  3'd0,
        rf_outb_sel:  3'd0,
        rf_fun_sel:   3'd0,
        rf_reg_sel:   4'hF,
        rf_scr_sel:   4'hF,
        alu_fun_sel:  5'd0,
        alu_wf:       1'b0,
        arf_outc_sel: 2'd0,
        arf_outd_sel: 2'd0,
        arf_fun_sel:  3'd0,
        arf_reg_sel:  3'b111,
        ir_lh:        1'b0,
        ir_write:     1'b0,
        mem_wr:       1'b0,
        mem_cs:       1'b1,
        muxa_sel:     2'd0,
        muxb_sel:     2'd0,
        muxc_sel:     1'b0
    };

    // Register read-select code for a 2-bit register field (R1..R4).
    function automatic logic [2:0] reg_sel_code(input logic [1:0] field);
        return {1'b0, field};
    endfunction

    // Active-low write enable {R1,R2,R3,R4} for a 2-bit register field.
    function automatic logic [3:0] reg_enable_n(input logic [1:0] field);
        return ~(4'b1000 >> field);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder
//   Purely combinational execute-phase decode: instruction register contents
//   plus ALU flags to the full datapath control word.
//   ir    in  16  instruction register contents
//   flags in  4   ALU flags {Z,C,N,O}
//   cw    out     control word for the execute cycle
//   halt  out 1   instruction is HLT
module instr_decoder
    import control_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    output ctrl_word_t  cw,
    output logic        halt
);

    logic [5:0] opcode;
    logic [1:0] dst;
    logic [1:0] src1;
    logic [1:0] src2;
    logic [1:0] rsel;
    logic       flag_z;
    logic       unused_flags;

    assign opcode       = ir[15:10];
    assign rsel         = ir[9:8];
    assign dst          = ir[5:4];
    assign src1         = ir[3:2];
    assign src2         = ir[1:0];
    assign flag_z       = flags[3];
    assign unused_flags = ^flags[2:0];

    always_comb begin
        cw   = IDLE_WORD;
        halt = 1'b0;
        case (opcode)
            OP_INC: begin
                cw.rf_fun_sel = FUN_INC;
                cw.rf_reg_sel = reg_enable_n(dst);
            end
            OP_DEC: begin
                cw.rf_fun_sel = FUN_DEC;
                cw.rf_reg_sel = reg_enable_n(dst);
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                cw.rf_outa_sel = reg_sel_code(src1);
                cw.rf_outb_sel = reg_sel_code(src2);
                case (opcode)
                    OP_SUB:  cw.alu_fun_sel = ALU_SUB;
                    OP_AND:  cw.alu_fun_sel = ALU_AND;
                    OP_ORR:  cw.alu_fun_sel = ALU_ORR;
                    default: cw.alu_fun_sel = ALU_ADD;
                endcase
                cw.alu_wf     = 1'b1;
                cw.muxa_sel   = MUXA_ALU;
                cw.rf_fun_sel = FUN_LOAD;
                cw.rf_reg_sel = reg_enable_n(dst);
            end
            OP_MOVL: begin
                // Datapath zero-extends IR[7:0] on the immediate mux leg.
                cw.muxa_sel   = MUXA_IMM;
                cw.rf_fun_sel = FUN_LOAD;
                cw.rf_reg_sel = reg_enable_n(rsel);
            end
            OP_LD: begin
                cw.arf_outd_sel = ARF_SEL_AR;
                cw.mem_cs       = 1'b0;
                cw.mem_wr       = 1'b0;
                cw.muxa_sel     = MUXA_MEM;
                cw.rf_fun_sel   = FUN_LOAD;
                cw.rf_reg_sel   = reg_enable_n(rsel);
            end
            OP_ST: begin
                cw.rf_outa_sel  = reg_sel_code(rsel);
                cw.alu_fun_sel  = ALU_PASS_A;
                cw.muxc_sel     = 1'b0;
                cw.arf_outd_sel = ARF_SEL_AR;
                cw.mem_cs       = 1'b0;
                cw.mem_wr       = 1'b1;
            end
            OP_BRA, OP_BEQ: begin
                // BEQ falls back to the idle word when Z is clear.
                if (opcode == OP_BRA || flag_z) begin
                    cw.arf_outc_sel = ARF_SEL_AR;
                    cw.muxb_sel     = MUXB_ARF;
                    cw.arf_fun_sel  = FUN_LOAD;
                    cw.arf_reg_sel  = ARF_WR_PC;
                end
            end
            OP_HLT: begin
                halt = 1'b1;
            end
            default: begin
                // NOP and unassigned opcodes: idle word
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Three-cycle fetch/fetch/execute instruction sequencer driving the 16-bit
//   datapath control-word interface, with a halt state.
//   Clock, Reset            system clock, synchronous active-high reset
//   IROut[15:0], Flags[3:0] instruction register and ALU flags from datapath
//   RF_*, ALU_*, ARF_*      register file / ALU / address register controls
//   IR_LH, IR_Write         instruction register byte select and load
//   Mem_WR, Mem_CS          memory direction and active-low chip select
//   MuxASel/MuxBSel/MuxCSel datapath mux selects
//   T[1:0]                  current state code (debug)
//   All control outputs are combinational from the state register and IROut.
module control_sequencer
    import control_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [1:0]  T
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t dec_cw;
    logic       dec_halt;
    ctrl_word_t cw;

    instr_decoder u_instr_decoder (
        .ir    (IROut),
        .flags (Flags),
        .cw    (dec_cw),
        .halt  (dec_halt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = dec_halt ? ST_HALT : ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        cw = IDLE_WORD;
        if (!Reset) begin
            case (state_q)
                ST_T0, ST_T1: begin
                    // Both fetch cycles read memory at PC and post-increment it.
                    cw.arf_outd_sel = ARF_SEL_PC;
                    cw.mem_cs       = 1'b0;
                    cw.ir_write     = 1'b1;
                    cw.ir_lh        = (state_q == ST_T1);
                    cw.arf_fun_sel  = FUN_INC;
                    cw.arf_reg_sel  = ARF_WR_PC;
                end
                ST_T2:   cw = dec_cw;
                default: cw = IDLE_WORD;
            endcase
        end
    end

    // Reset forces the debug state code to T0 immediately, ahead of the edge.
    assign T = Reset ? ST_T0 : state_q;

    assign RF_OutASel  = cw.rf_outa_sel;
    assign RF_OutBSel  = cw.rf_outb_sel;
    assign RF_FunSel   = cw.rf_fun_sel;
    assign RF_RegSel   = cw.rf_reg_sel;
    assign RF_ScrSel   = cw.rf_scr_sel;
    assign ALU_FunSel  = cw.alu_fun_sel;
    assign ALU_WF      = cw.alu_wf;
    assign ARF_OutCSel = cw.arf_outc_sel;
    assign ARF_OutDSel = cw.arf_outd_sel;
    assign ARF_FunSel  = cw.arf_fun_sel;
    assign ARF_RegSel  = cw.arf_reg_sel;
    assign IR_LH       = cw.ir_lh;
    assign IR_Write    = cw.ir_write;
    assign Mem_WR      = cw.mem_wr;
    assign Mem_CS      = cw.mem_cs;
    assign MuxASel     = cw.muxa_sel;
    assign MuxBSel     = cw.muxb_sel;
    assign MuxCSel     = cw.muxc_sel;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed-vector bench for control_sequencer: whole control words are
//   compared against hand-built expected words one cycle at a time.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IROut = 16'h0000;
    logic [3:0]  Flags = 4'h0;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [1:0]  T;

    control_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .Flags       (Flags),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RegSel   (RF_RegSel),
        .RF_ScrSel   (RF_ScrSel),
        .ALU_FunSel  (ALU_FunSel),
        .ALU_WF      (ALU_WF),
        .ARF_OutCSel (ARF_OutCSel),
        .ARF_OutDSel (ARF_OutDSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .IR_LH       (IR_LH),
        .IR_Write    (IR_Write),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .T           (T)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] outa;
        logic [2:0] outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] outc;
        logic [1:0] outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxa;
        logic [1:0] muxb;
        logic       muxc;
    } word_t;

    word_t obs;
    assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                  ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                  ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS,
                  MuxASel, MuxBSel, MuxCSel};

    localparam word_t IDLE_W = '{
        outa: 3'd0, outb: 3'd0, rf_fun: 3'd0, rf_reg: 4'hF, rf_scr: 4'hF,
        alu_fun: 5'd0, alu_wf: 1'b0, outc: 2'd0, outd: 2'd0, arf_fun: 3'd0,
        arf_reg: 3'b111, ir_lh: 1'b0, ir_write: 1'b0, mem_wr: 1'b0,
        mem_cs: 1'b1, muxa: 2'd0, muxb: 2'd0, muxc: 1'b0
    };

    int vectors     = 0;
    int miscompares = 0;

    function automatic word_t fetch_w(input logic lh);
        word_t w;
        w          = IDLE_W;
        w.outd     = 2'b00;
        w.mem_cs   = 1'b0;
        w.ir_write = 1'b1;
        w.ir_lh    = lh;
        w.arf_fun  = 3'b001;
        w.arf_reg  = 3'b011;
        return w;
    endfunction

    function automatic word_t branch_w();
        word_t w;
        w         = IDLE_W;
        w.outc    = 2'b10;
        w.muxb    = 2'b01;
        w.arf_fun = 3'b010;
        w.arf_reg = 3'b011;
        return w;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Always steps at least once; bounded so a stuck sequencer cannot hang.
    task automatic advance_to(input logic [1:0] target);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (T !== target && n < 4);
        if (T !== target) begin
            vectors++;
            miscompares++;
            $display("FAIL advance_to: T=%b required %b", T, target);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (T !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_T: got %b required 00", T);
        end
        vectors++;
        if (obs !== IDLE_W) begin
            miscompares++;
            $display("FAIL reset_word: got %h required %h", obs, IDLE_W);
        end
    endtask

    task automatic test_fetch_cycle();
        logic [1:0] exp_t [4];
        word_t      exp_w [4];
        exp_t = '{2'b00, 2'b01, 2'b10, 2'b00};
        exp_w = '{fetch_w(1'b0), fetch_w(1'b1), IDLE_W, fetch_w(1'b0)};
        IROut = 16'h0000;
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            vectors++;
            if (T !== exp_t[i]) begin
                miscompares++;
                $display("FAIL fetch_T[%0d]: got %b required %b", i, T, exp_t[i]);
            end
            vectors++;
            if (obs !== exp_w[i]) begin
                miscompares++;
                $display("FAIL fetch_word[%0d]: got %h required %h", i, obs, exp_w[i]);
            end
        end
    endtask

    task automatic test_movl();
        word_t e;
        IROut = 16'h1C1B;   // R field 00 -> R1
        advance_to(2'b10);
        e        = IDLE_W;
        e.muxa   = 2'b11;
        e.rf_fun = 3'b010;
        e.rf_reg = 4'b0111;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL movl_r1: got %h required %h", obs, e);
        end
        IROut = 16'h1F1B;   // R field 11 -> R4
        advance_to(2'b10);
        e.rf_reg = 4'b1110;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL movl_r4: got %h required %h", obs, e);
        end
    endtask

    task automatic test_alu_ops();
        logic [15:0] ir_t   [4];
        logic [2:0]  a_t    [4];
        logic [2:0]  b_t    [4];
        logic [4:0]  alu_t  [4];
        logic [3:0]  reg_t  [4];
        word_t e;
        ir_t  = '{16'h0C16, 16'h1031, 16'h140E, 16'h1828};
        a_t   = '{3'd1, 3'd0, 3'd3, 3'd2};
        b_t   = '{3'd2, 3'd1, 3'd2, 3'd0};
        alu_t = '{5'h14, 5'h16, 5'h17, 5'h18};
        reg_t = '{4'b1011, 4'b1110, 4'b0111, 4'b1101};
        for (int i = 0; i < 4; i++) begin
            IROut = ir_t[i];
            advance_to(2'b10);
            e         = IDLE_W;
            e.outa    = a_t[i];
            e.outb    = b_t[i];
            e.alu_fun = alu_t[i];
            e.alu_wf  = 1'b1;
            e.muxa    = 2'b00;
            e.rf_fun  = 3'b010;
            e.rf_reg  = reg_t[i];
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL alu_op %h: got %h required %h", ir_t[i], obs, e);
            end
        end
    endtask

    task automatic test_inc_dec();
        word_t e;
        IROut = 16'h0420;   // INC, DST=R3
        advance_to(2'b10);
        e        = IDLE_W;
        e.rf_fun = 3'b001;
        e.rf_reg = 4'b1101;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL inc: got %h required %h", obs, e);
        end
        IROut = 16'h0800;   // DEC, DST=R1
        advance_to(2'b10);
        e.rf_fun = 3'b000;
        e.rf_reg = 4'b0111;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL dec: got %h required %h", obs, e);
        end
    endtask

    task automatic test_ld_st();
        word_t e;
        IROut = 16'h2300;   // LD R4
        advance_to(2'b10);
        e        = IDLE_W;
        e.outd   = 2'b10;
        e.mem_cs = 1'b0;
        e.muxa   = 2'b10;
        e.rf_fun = 3'b010;
        e.rf_reg = 4'b1110;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL ld: got %h required %h", obs, e);
        end
        IROut = 16'h2500;   // ST R2
        advance_to(2'b10);
        e         = IDLE_W;
        e.outa    = 3'b001;
        e.alu_fun = 5'h10;
        e.outd    = 2'b10;
        e.mem_cs  = 1'b0;
        e.mem_wr  = 1'b1;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL st: got %h required %h", obs, e);
        end
    endtask

    task automatic test_branch();
        Flags = 4'b0000;
        IROut = 16'h2800;   // BRA ignores flags
        advance_to(2'b10);
        vectors++;
        if (obs !== branch_w()) begin
            miscompares++;
            $display("FAIL bra: got %h required %h", obs, branch_w());
        end
        IROut = 16'h2C00;   // BEQ
        Flags = 4'b1000;
        advance_to(2'b10);
        vectors++;
        if (obs !== branch_w()) begin
            miscompares++;
            $display("FAIL beq_taken: got %h required %h", obs, branch_w());
        end
        Flags = 4'b0111;    // Z clear, other flags set
        #1;
        vectors++;
        if (obs !== IDLE_W) begin
            miscompares++;
            $display("FAIL beq_not_taken: got %h required %h", obs, IDLE_W);
        end
        Flags = 4'b0000;
        IROut = 16'h3000;   // unassigned opcode 0C
        advance_to(2'b10);
        vectors++;
        if (obs !== IDLE_W) begin
            miscompares++;
            $display("FAIL undefined_op: got %h required %h", obs, IDLE_W);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        IROut = 16'h0C16;
        advance_to(2'b00);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = 2'(k % 3);
            vectors++;
            if (T !== exp) begin
                miscompares++;
                $display("FAIL b2b_T[%0d]: got %b required %b", k, T, exp);
            end
        end
    endtask

    task automatic test_halt();
        IROut = 16'hFC00;
        advance_to(2'b10);
        vectors++;
        if (obs !== IDLE_W) begin
            miscompares++;
            $display("FAIL hlt_exec: got %h required %h", obs, IDLE_W);
        end
        for (int k = 0; k < 11; k++) begin
            tick();
            vectors++;
            if (T !== 2'b11 || obs !== IDLE_W) begin
                miscompares++;
                $display("FAIL halt_hold[%0d]: got T=%b word=%h required T=11 word=%h",
                         k, T, obs, IDLE_W);
            end
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if (T !== 2'b00 || obs !== IDLE_W) begin
            miscompares++;
            $display("FAIL halt_reset_forced: got T=%b word=%h required T=00 word=%h",
                     T, obs, IDLE_W);
        end
        tick();
        Reset = 1'b0;
        #1;
        vectors++;
        if (T !== 2'b00 || obs !== fetch_w(1'b0)) begin
            miscompares++;
            $display("FAIL halt_restart: got T=%b word=%h required T=00 word=%h",
                     T, obs, fetch_w(1'b0));
        end
    endtask

    task automatic test_reset_mid();
        IROut = 16'h0000;
        advance_to(2'b01);
        Reset = 1'b1;
        tick();
        vectors++;
        if (T !== 2'b00 || obs !== IDLE_W) begin
            miscompares++;
            $display("FAIL reset_mid: got T=%b word=%h required T=00 word=%h",
                     T, obs, IDLE_W);
        end
        Reset = 1'b0;
        #1;
        vectors++;
        if (T !== 2'b00 || obs !== fetch_w(1'b0)) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: got T=%b word=%h required T=00 word=%h",
                     T, obs, fetch_w(1'b0));
        end
        tick();
        vectors++;
        if (T !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_T1: got %b required 01", T);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_cycle();
        test_movl();
        test_alu_ops();
        test_inc_dec();
        test_ld_st();
        test_branch();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
